// File: rtl/pwm_pkg.sv
// Shared widths, types and reset constants for the PWM compare slice.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  localparam int unsigned PWM_RST_DUTY = 0;

endpackage : pwm_pkg

// File: rtl/duty_shadow.sv
// Double-buffered duty register: a pending slot filled over valid/ready and
// transferred to the active slot only when the period wraps.
module duty_shadow
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned RST_DUTY = PWM_RST_DUTY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  input  logic             boundary,
  output logic             duty_ready,
  output logic [WIDTH-1:0] duty_active,
  output logic             update_applied
);

  logic             pending_q, pending_d;
  logic [WIDTH-1:0] pendVal_q, pendVal_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             applied_q, applied_d;
  logic             accept;
  logic             load;

  // Accept and load are mutually exclusive: accept needs the slot empty,
  // load needs it full, so a value accepted on a boundary waits one period.
  assign accept = duty_valid & ~pending_q;
  assign load   = boundary & pending_q;

  always_comb begin
    pending_d = pending_q;
    pendVal_d = pendVal_q;
    active_d  = active_q;
    applied_d = load;
    if (load) begin
      active_d  = pendVal_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      pendVal_d = duty_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      pendVal_q <= '0;
      active_q  <= WIDTH'(RST_DUTY);
      applied_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pendVal_q <= pendVal_d;
      active_q  <= active_d;
      applied_q <= applied_d;
    end
  end

  assign duty_ready     = ~pending_q;
  assign duty_active    = active_q;
  assign update_applied = applied_q;

endmodule : duty_shadow

// File: rtl/pwm_compare.sv
// Registered PWM generator comparing the shared counter value against a
// boundary-synchronised duty, plus period and update strobes.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned RST_DUTY = PWM_RST_DUTY,
  parameter bit          INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_val,
  input  logic             cnt_reached,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [WIDTH-1:0] duty_active,
  output logic             pwm_out,
  output logic             period_done,
  output logic             update_applied
);

  logic boundary;
  logic pwm_q, pwm_d;
  logic periodDone_q, periodDone_d;

  // A stalled counter sitting on its terminal value is not a wrap.
  assign boundary = cnt_reached & cnt_en;

  duty_shadow #(
    .WIDTH    (WIDTH),
    .RST_DUTY (RST_DUTY)
  ) u_shadow (
    .clk            (clk),
    .rst            (rst),
    .duty_in        (duty_in),
    .duty_valid     (duty_valid),
    .boundary       (boundary),
    .duty_ready     (duty_ready),
    .duty_active    (duty_active),
    .update_applied (update_applied)
  );

  // Compare uses this cycle's active duty, so the terminal count still sees
  // the old value and a newly loaded duty first applies to count 0.
  always_comb begin
    pwm_d        = (cnt_val < duty_active) ^ INVERT;
    periodDone_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q        <= INVERT;
      periodDone_q <= 1'b0;
    end else begin
      pwm_q        <= pwm_d;
      periodDone_q <= periodDone_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = periodDone_q;

endmodule : pwm_compare

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: a normal and an inverted build share one
// stimulus stream driven by a behavioural 8-bit counter.
module tb_pwm_compare;
  import pwm_pkg::*;

  logic  clk;
  logic  rst;
  duty_t cntVal;
  logic  cntReached;
  logic  cntEn;
  duty_t dutyIn;
  logic  dutyValid;

  logic  ready, pwm, pd, ua;
  duty_t active;
  logic  invReady, invPwm, invPd, invUa;
  duty_t invActive;

  int total = 0;
  int bad   = 0;
  int hiCnt, invHiCnt, pdCnt, uaCnt;

  assign cntReached = (cntVal == 8'hFF);

  pwm_compare #(.WIDTH(8), .RST_DUTY(0), .INVERT(1'b0)) dut (
    .clk            (clk),
    .rst            (rst),
    .cnt_val        (cntVal),
    .cnt_reached    (cntReached),
    .cnt_en         (cntEn),
    .duty_in        (dutyIn),
    .duty_valid     (dutyValid),
    .duty_ready     (ready),
    .duty_active    (active),
    .pwm_out        (pwm),
    .period_done    (pd),
    .update_applied (ua)
  );

  pwm_compare #(.WIDTH(8), .RST_DUTY(0), .INVERT(1'b1)) dutInv (
    .clk            (clk),
    .rst            (rst),
    .cnt_val        (cntVal),
    .cnt_reached    (cntReached),
    .cnt_en         (cntEn),
    .duty_in        (dutyIn),
    .duty_valid     (dutyValid),
    .duty_ready     (invReady),
    .duty_active    (invActive),
    .pwm_out        (invPwm),
    .period_done    (invPd),
    .update_applied (invUa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    hiCnt    = 0;
    invHiCnt = 0;
    pdCnt    = 0;
    uaCnt    = 0;
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then the
  // behavioural counter advances for the next edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pwm)    hiCnt++;
      if (invPwm) invHiCnt++;
      if (pd)     pdCnt++;
      if (ua)     uaCnt++;
      if (cntEn && !rst) cntVal = cntVal + 8'd1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    cntEn     = 1'b1;
    cntVal    = 8'd0;
    dutyIn    = 8'd0;
    dutyValid = 1'b0;
    clearCounts();

    applyStimulus(2);
    checkOutput("rst_pwm",    int'(pwm),    0);
    checkOutput("rst_invpwm", int'(invPwm), 1);
    checkOutput("rst_pd",     int'(pd),     0);
    checkOutput("rst_ua",     int'(ua),     0);
    checkOutput("rst_ready",  int'(ready),  1);
    checkOutput("rst_active", int'(active), 0);
    rst = 1'b0;

    // Basic update: 64 offered at count 100
    applyStimulus(100);
    dutyIn    = 8'd64;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyValid = 1'b0;
    checkOutput("basic_ready", int'(ready),  0);
    checkOutput("basic_act0",  int'(active), 0);
    clearCounts();
    applyStimulus(154);
    checkOutput("basic_pre_hi", hiCnt, 0);
    checkOutput("basic_pre_pd", pdCnt, 0);
    applyStimulus(1);
    checkOutput("basic_bnd_pd",  int'(pd),     1);
    checkOutput("basic_bnd_ua",  int'(ua),     1);
    checkOutput("basic_bnd_act", int'(active), 64);
    checkOutput("basic_bnd_pwm", int'(pwm),    0);
    clearCounts();
    applyStimulus(64);
    checkOutput("basic_hi64",    hiCnt,    64);
    checkOutput("basic_invhi64", invHiCnt, 0);
    clearCounts();
    applyStimulus(192);
    checkOutput("basic_lo192",    hiCnt,    0);
    checkOutput("basic_invlo192", invHiCnt, 192);
    checkOutput("basic_pd1",      pdCnt,    1);
    checkOutput("basic_ua0",      uaCnt,    0);

    // Back-to-back: 32 accepted, 200 stalled until after the boundary
    applyStimulus(10);
    dutyIn    = 8'd32;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyIn    = 8'd200;
    clearCounts();
    applyStimulus(244);
    checkOutput("b2b_ready_stall", int'(ready), 0);
    checkOutput("b2b_hi_mid",      hiCnt,       53);
    applyStimulus(1);
    checkOutput("b2b_bnd_act",   int'(active), 32);
    checkOutput("b2b_bnd_ua",    int'(ua),     1);
    checkOutput("b2b_bnd_ready", int'(ready),  1);
    clearCounts();
    applyStimulus(1);
    dutyValid = 1'b0;
    checkOutput("b2b_acc_ready", int'(ready), 0);
    checkOutput("b2b_acc_ua",    int'(ua),    0);
    applyStimulus(255);
    checkOutput("b2b_hi32",  hiCnt,        32);
    checkOutput("b2b_pd",    pdCnt,        1);
    checkOutput("b2b_ua",    uaCnt,        1);
    checkOutput("b2b_act",   int'(active), 200);
    clearCounts();
    applyStimulus(256);
    checkOutput("b2b_hi200", hiCnt, 200);
    checkOutput("b2b_ua0",   uaCnt, 0);

    // Accept exactly on the boundary cycle: not applied until next wrap
    applyStimulus(255);
    dutyIn    = 8'd128;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyValid = 1'b0;
    checkOutput("onbnd_act",   int'(active), 200);
    checkOutput("onbnd_ua",    int'(ua),     0);
    checkOutput("onbnd_pd",    int'(pd),     1);
    checkOutput("onbnd_ready", int'(ready),  0);
    clearCounts();
    applyStimulus(256);
    checkOutput("onbnd_hi200", hiCnt,        200);
    checkOutput("onbnd_ua1",   uaCnt,        1);
    checkOutput("onbnd_act2",  int'(active), 128);
    clearCounts();
    applyStimulus(256);
    checkOutput("onbnd_hi128", hiCnt, 128);

    // Stall at terminal with duty 0 pending
    applyStimulus(5);
    dutyIn    = 8'd0;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyValid = 1'b0;
    applyStimulus(249);
    cntEn = 1'b0;
    clearCounts();
    applyStimulus(10);
    checkOutput("stall_pd",    pdCnt,        0);
    checkOutput("stall_ua",    uaCnt,        0);
    checkOutput("stall_hi",    hiCnt,        0);
    checkOutput("stall_act",   int'(active), 128);
    checkOutput("stall_ready", int'(ready),  0);
    cntEn = 1'b1;
    applyStimulus(1);
    checkOutput("stall_end_pd",  int'(pd),     1);
    checkOutput("stall_end_ua",  int'(ua),     1);
    checkOutput("stall_end_act", int'(active), 0);

    // Duty 0 for three periods
    clearCounts();
    applyStimulus(768);
    checkOutput("d0_hi",    hiCnt,    0);
    checkOutput("d0_invhi", invHiCnt, 768);
    checkOutput("d0_pd",    pdCnt,    3);

    // Duty 255: 255 high / 1 low
    dutyIn    = 8'd255;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyValid = 1'b0;
    applyStimulus(255);
    checkOutput("d255_act", int'(active), 255);
    clearCounts();
    applyStimulus(256);
    checkOutput("d255_hi",    hiCnt,    255);
    checkOutput("d255_invhi", invHiCnt, 1);

    // Reset drops a pending value
    applyStimulus(50);
    dutyIn    = 8'd77;
    dutyValid = 1'b1;
    applyStimulus(1);
    dutyValid = 1'b0;
    checkOutput("rst2_pre_ready", int'(ready), 0);
    rst = 1'b1;
    applyStimulus(1);
    rst    = 1'b0;
    cntVal = 8'd0;
    checkOutput("rst2_ready",  int'(ready),  1);
    checkOutput("rst2_act",    int'(active), 0);
    checkOutput("rst2_pwm",    int'(pwm),    0);
    checkOutput("rst2_invpwm", int'(invPwm), 1);
    checkOutput("rst2_ua",     int'(ua),     0);
    clearCounts();
    applyStimulus(256);
    checkOutput("rst2_ua_after",  uaCnt,        0);
    checkOutput("rst2_act_after", int'(active), 0);
    checkOutput("rst2_hi_after",  hiCnt,        0);
    checkOutput("rst2_pd_after",  pdCnt,        1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_compare

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
- Downstream consumer of the 8-bit free-running counter's `val` / `reached` outputs.
- Compares the running count against a double-buffered duty value and produces a registered PWM waveform.
- Duty updates arrive over a valid/ready handshake. They are staged in a shadow register and take effect only at a period boundary, so the output never glitches mid-period.
- Also emits period and update-applied strobes for the control logic.

Parameters:
- WIDTH, 8: count/duty width; must match the counter width.
- RST_DUTY, 0: active duty value after reset.
- INVERT, 0: 1 = `pwm_out` is active-low (the compare result is inverted before the output register).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cnt_val` input WIDTH: current count from the counter stage.
- `cnt_reached` input 1: counter is at its terminal value (the last count of the period).
- `cnt_en` input 1: counter advances this cycle (same enable that drives the counter).
- `duty_in` input WIDTH: requested duty (number of high counts per period).
- `duty_valid` input 1: `duty_in` is valid.
- `duty_ready` output 1: shadow register can accept a new duty.
- `duty_active` output WIDTH: duty currently in effect.
- `pwm_out` output 1: registered PWM output.
- `period_done` output 1: one-cycle pulse, one cycle after each period boundary.
- `update_applied` output 1: one-cycle pulse, one cycle after a pending duty is loaded into the active register.

Behaviour:
- All state updates on the rising `clk` edge; `rst` is sampled synchronously.
- Reset values:
  - `duty_active` = RST_DUTY
  - pending flag = 0, so `duty_ready` = 1
  - pending value = 0
  - `pwm_out` = INVERT
  - `period_done` = 0
  - `update_applied` = 0
- Reset mid-period discards any pending duty; there is no carry-over.
- Boundary event: `boundary = cnt_reached & cnt_en`.
  - `cnt_reached` held high while `cnt_en` = 0 (counter stalled at terminal) is not a boundary: no load, no `period_done`.
- Handshake:
  - `duty_ready = ~pending_flag`; it is a registered state, never combinational on `duty_valid`.
  - Accept on `duty_valid & duty_ready`: pending value ← `duty_in`, pending flag ← 1.
  - `duty_in` is ignored while `duty_ready` = 0; the producer holds `duty_valid` until accepted.
- Load on `boundary & pending_flag`: `duty_active` ← pending value, pending flag ← 0, `update_applied` ← 1 on the next cycle.
- Same-cycle accept and boundary: only possible with pending empty. The value is captured into pending only. It is not applied at this boundary; it is applied at the following one.
- Same-cycle load and `duty_valid`: `duty_ready` was 0, so there is no accept. Ready returns to 1 the next cycle.
- Compare:
  - `pwm_out` ← (`cnt_val` < `duty_active`) XOR INVERT, one cycle of latency from `cnt_val`.
  - The compare always uses the `duty_active` register value of the current cycle. The terminal count is compared against the old duty; the new duty first affects count 0.
- Width rules:
  - Unsigned compare, WIDTH bits, no extension tricks.
  - duty = 0 gives a constant inactive output.
  - duty = 2^WIDTH−1 with terminal 2^WIDTH−1 gives active for 255 of 256 counts.
  - 100% duty is not representable; this is by design.
- Counter stall (`cnt_en` = 0): `pwm_out` keeps tracking `cnt_val` each cycle; the period simply lengthens.
- `period_done` ← `boundary`, registered.

Decomposition:
- Shared package `pwm_pkg`:
  - `PWM_WIDTH` = 8
  - `duty_t` = logic [PWM_WIDTH-1:0]
  - `PWM_RST_DUTY` constant
- Natural sub-module: `duty_shadow`. It holds the pending register, pending flag, active register, handshake and `update_applied` logic. Its inputs are `duty_in`/`duty_valid`/`boundary`; its outputs are `duty_ready`/`duty_active`/`update_applied`.
- The compare and output register stay in `pwm_compare`.

Test Plan:
- Reset: hold `rst` = 1 for 2 cycles with `cnt_en` = 1 → `pwm_out` = 0, `period_done` = 0, `update_applied` = 0, `duty_ready` = 1, `duty_active` = 0.
- Basic update:
  - Stimulus: with `cnt_en` = 1 and the counter wrapping 255→0, present `duty_in` = 64 at `cnt_val` = 100.
  - `duty_ready` = 0 next cycle; `pwm_out` stays 0 through the period.
  - Boundary at `cnt_val` = 255 → `update_applied` and `period_done` pulse, `duty_active` = 64.
  - `pwm_out` = 1 for exactly 64 consecutive cycles, lagging `cnt_val` 0..63 by one cycle, then 0 for 192.
- Back-to-back requests: offer 32 then 200 in the same period → 200 is stalled (`duty_ready` = 0). After the boundary, 32 is active and 200 is accepted; at the next boundary 200 is active (200 high cycles per 256).
- Accept on boundary cycle: `duty_valid` with `duty_in` = 128 asserted exactly when `cnt_val` = 255 and `cnt_en` = 1, pending empty → `duty_active` unchanged at that boundary and no `update_applied`; 128 becomes active one period later.
- Stall at terminal: `cnt_val` = 255, `cnt_reached` = 1, `cnt_en` = 0 for 10 cycles with a pending duty → no load, no `period_done` during the stall; both occur one cycle after `cnt_en` returns to 1.
- Edge duties and reset:
  - duty 0 → `pwm_out` never 1 over 3 periods.
  - duty 255 → 255 high / 1 low per period.
  - `rst` pulse with a pending value → pending dropped, `duty_ready` = 1, `duty_active` = RST_DUTY.
  - INVERT = 1 build → waveforms complemented, reset `pwm_out` = 1.
